serdes_enc_scheduler: RTL and testbench

SERDES_ENC_SCHEDULER -- requirements
Module: serdes_enc_scheduler

---
 rtl/serdes_enc_scheduler.sv | 181 ++++++++++++++++++
 tb/tb_serdes_enc_scheduler.sv | 366 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/serdes_enc_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : serdes_enc_scheduler
// Description : Arbitrates two operand-pair requesters onto a bit-serial
//               encrypt core. A granted pair is sent MSB first over eight
//               SHIFT cycles, the core result (or a timeout error) is held
//               on the response port until the consumer accepts it.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clk, rst                  clock, asynchronous active-high reset
//   req{0,1}_valid/_a/_b      requester operand pair offers
//   req{0,1}_ready            one-cycle accept strobe per requester
//   core_start                one-cycle start pulse to the serial core
//   core_a_bit, core_b_bit    serial operand bits, MSB first
//   core_done, core_cipher    core completion flag and result byte
//   rsp_valid/_ready          response handshake
//   rsp_id, rsp_data, rsp_err response requester index, data, timeout flag
//   busy                      high whenever the scheduler is not idle
// ============================================================================
module serdes_enc_scheduler #(
    parameter int TIMEOUT = 32
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       req0_valid,
    input  logic [7:0] req0_a,
    input  logic [7:0] req0_b,
    output logic       req0_ready,
    input  logic       req1_valid,
    input  logic [7:0] req1_a,
    input  logic [7:0] req1_b,
    output logic       req1_ready,
    output logic       core_start,
    output logic       core_a_bit,
    output logic       core_b_bit,
    input  logic       core_done,
    input  logic [7:0] core_cipher,
    output logic       rsp_valid,
    input  logic       rsp_ready,
    output logic       rsp_id,
    output logic [7:0] rsp_data,
    output logic       rsp_err,
    output logic       busy
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_START = 3'd1,
        S_SHIFT = 3'd2,
        S_WAIT  = 3'd3,
        S_RESP  = 3'd4
    } state_t;

    // Last WAIT cycle in which a missing core_done still counts as on time.
    localparam logic [7:0] c_TMO_LAST = 8'(TIMEOUT - 1);

    state_t     state_q, state_d;
    logic [2:0] bit_cnt_q, bit_cnt_d;
    logic [7:0] tmo_cnt_q, tmo_cnt_d;
    logic [7:0] op_a_q, op_a_d;
    logic [7:0] op_b_q, op_b_d;
    logic       id_q, id_d;
    // Set when requester 1 was granted last; reset value favours requester 0.
    logic       last_gnt1_q, last_gnt1_d;
    logic       rsp_id_q, rsp_id_d;
    logic [7:0] rsp_data_q, rsp_data_d;
    logic       rsp_err_q, rsp_err_d;
    logic       w_gnt0, w_gnt1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            bit_cnt_q   <= 3'd0;
            tmo_cnt_q   <= 8'd0;
            op_a_q      <= 8'd0;
            op_b_q      <= 8'd0;
            id_q        <= 1'b0;
            last_gnt1_q <= 1'b1;
            rsp_id_q    <= 1'b0;
            rsp_data_q  <= 8'd0;
            rsp_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            tmo_cnt_q   <= tmo_cnt_d;
            op_a_q      <= op_a_d;
            op_b_q      <= op_b_d;
            id_q        <= id_d;
            last_gnt1_q <= last_gnt1_d;
            rsp_id_q    <= rsp_id_d;
            rsp_data_q  <= rsp_data_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        tmo_cnt_d   = tmo_cnt_q;
        op_a_d      = op_a_q;
        op_b_d      = op_b_q;
        id_d        = id_q;
        last_gnt1_d = last_gnt1_q;
        rsp_id_d    = rsp_id_q;
        rsp_data_d  = rsp_data_q;
        rsp_err_d   = rsp_err_q;
        w_gnt0      = 1'b0;
        w_gnt1      = 1'b0;

        case (state_q)
            S_IDLE: begin
                // The ready strobes are combinational, so they are masked
                // while reset is held to keep every output at zero.
                if (!rst) begin
                    if (req0_valid && (!req1_valid || last_gnt1_q)) begin
                        w_gnt0 = 1'b1;
                    end else if (req1_valid) begin
                        w_gnt1 = 1'b1;
                    end
                end
                if (w_gnt0 || w_gnt1) begin
                    op_a_d      = w_gnt1 ? req1_a : req0_a;
                    op_b_d      = w_gnt1 ? req1_b : req0_b;
                    id_d        = w_gnt1;
                    last_gnt1_d = w_gnt1;
                    state_d     = S_START;
                end
            end
            S_START: begin
                bit_cnt_d = 3'd0;
                state_d   = S_SHIFT;
            end
            S_SHIFT: begin
                if (bit_cnt_q == 3'd7) begin
                    tmo_cnt_d = 8'd0;
                    state_d   = S_WAIT;
                end else begin
                    bit_cnt_d = bit_cnt_q + 3'd1;
                end
            end
            S_WAIT: begin
                // core_done is tested first so it wins over a same-cycle expiry.
                if (core_done) begin
                    rsp_id_d   = id_q;
                    rsp_data_d = core_cipher;
                    rsp_err_d  = 1'b0;
                    state_d    = S_RESP;
                end else if (tmo_cnt_q == c_TMO_LAST) begin
                    rsp_id_d   = id_q;
                    rsp_data_d = 8'h00;
                    rsp_err_d  = 1'b1;
                    state_d    = S_RESP;
                end else begin
                    tmo_cnt_d = tmo_cnt_q + 8'd1;
                end
            end
            S_RESP: begin
                if (rsp_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign req0_ready = w_gnt0;
    assign req1_ready = w_gnt1;
    assign core_start = (state_q == S_START);
    assign core_a_bit = (state_q == S_SHIFT) ? op_a_q[3'd7 - bit_cnt_q] : 1'b0;
    assign core_b_bit = (state_q == S_SHIFT) ? op_b_q[3'd7 - bit_cnt_q] : 1'b0;
    assign rsp_valid  = (state_q == S_RESP);
    assign rsp_id     = rsp_id_q;
    assign rsp_data   = rsp_data_q;
    assign rsp_err    = rsp_err_q;
    assign busy       = (state_q != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_serdes_enc_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : tb_serdes_enc_scheduler
// Description : Scoreboard bench for serdes_enc_scheduler. Accepted requests
//               push expected responses predicted from the arbitration and
//               timing rules; a behavioural serial core checks the bit
//               stream; a monitor pops and compares each response.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_serdes_enc_scheduler;

    localparam int TIMEOUT = 32;
    localparam int NEVER   = 100000;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       vld [2];
    logic [7:0] opa [2];
    logic [7:0] opb [2];
    int         pw  [2];
    logic [7:0] pcip[2];
    logic       acc [2];
    logic       core_done   = 1'b0;
    logic [7:0] core_cipher = 8'h00;
    logic       rsp_ready   = 1'b0;

    logic       req0_ready, req1_ready, core_start, core_a_bit, core_b_bit;
    logic       rsp_valid, rsp_id, rsp_err, busy;
    logic [7:0] rsp_data;

    serdes_enc_scheduler #(.TIMEOUT(TIMEOUT)) dut (
        .clk        (clk),
        .rst        (rst),
        .req0_valid (vld[0]),
        .req0_a     (opa[0]),
        .req0_b     (opb[0]),
        .req0_ready (req0_ready),
        .req1_valid (vld[1]),
        .req1_a     (opa[1]),
        .req1_b     (opb[1]),
        .req1_ready (req1_ready),
        .core_start (core_start),
        .core_a_bit (core_a_bit),
        .core_b_bit (core_b_bit),
        .core_done  (core_done),
        .core_cipher(core_cipher),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_id     (rsp_id),
        .rsp_data   (rsp_data),
        .rsp_err    (rsp_err),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct { int id; int data; int err; int cyc; } rsp_t;
    typedef struct { int a; int b; int w; int cip; } plan_t;

    rsp_t  sb[$];
    plan_t plans[$];
    int    glog[$];
    int    n_tests = 0;
    int    n_fail  = 0;

    bit    auto_en   = 1'b0;
    bit    keep_both = 1'b0;
    int    spur_mode = 0;   // 0 random, 1 every shift cycle, 2 never

    task automatic chk(input string nm, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // ------------------------------------------------------------------
    // Reference model: arbitration, grant timing, expected responses.
    // ------------------------------------------------------------------
    bit idle_m    = 1'b1;
    bit last_m    = 1'b1;   // last grant went to requester 1
    int start_cyc = -1;
    int rsp_cyc   = 0;
    int m_g;
    bit m_err, e0, e1;

    always @(negedge clk) begin
        if (rst) begin
            chk("reset_outputs",
                32'({req0_ready, req1_ready, core_start, core_a_bit, core_b_bit,
                     rsp_valid, rsp_id, rsp_err, busy, rsp_data}), 0);
            idle_m    = 1'b1;
            last_m    = 1'b1;
            start_cyc = -1;
            sb.delete();
            plans.delete();
        end else begin
            chk("busy", busy, !idle_m);
            chk("core_start", core_start, cyc == start_cyc);
            e0 = 1'b0;
            e1 = 1'b0;
            if (idle_m && (vld[0] || vld[1])) begin
                if (vld[0] && vld[1]) m_g = last_m ? 0 : 1;
                else                  m_g = vld[1] ? 1 : 0;
                if (m_g == 0) e0 = 1'b1; else e1 = 1'b1;
                m_err   = (pw[m_g] >= TIMEOUT);
                rsp_cyc = cyc + 10 + (m_err ? TIMEOUT : pw[m_g] + 1);
                sb.push_back('{m_g, m_err ? 0 : int'(pcip[m_g]), int'(m_err), rsp_cyc});
                plans.push_back('{int'(opa[m_g]), int'(opb[m_g]), pw[m_g], int'(pcip[m_g])});
                glog.push_back(m_g);
                start_cyc = cyc + 1;
                acc[m_g]  = 1'b1;
                last_m    = (m_g == 1);
                idle_m    = 1'b0;
            end else if (!idle_m && cyc >= rsp_cyc && rsp_ready) begin
                idle_m = 1'b1;
            end
            chk("req0_ready", req0_ready, e0);
            chk("req1_ready", req1_ready, e1);
        end
    end

    // ------------------------------------------------------------------
    // Behavioural serial core: checks bits, answers after the planned delay.
    // ------------------------------------------------------------------
    plan_t cur;
    bit    collecting = 1'b0;
    int    kbit = 0;
    int    dcnt = -1;

    always @(negedge clk) begin
        if (rst) begin
            collecting = 1'b0;
            dcnt       = -1;
            core_done  = 1'b0;
        end else begin
            core_done   = 1'b0;
            core_cipher = 8'($urandom);
            if (collecting) begin
                chk("core_a_bit", core_a_bit, (cur.a >> (7 - kbit)) & 1);
                chk("core_b_bit", core_b_bit, (cur.b >> (7 - kbit)) & 1);
                // Spurious completions while the operands are still shifting.
                if (spur_mode == 1) core_done = 1'b1;
                else if (spur_mode == 0) core_done = ($urandom_range(0, 2) == 0);
                if (kbit == 7) begin
                    collecting = 1'b0;
                    dcnt       = cur.w;
                end else begin
                    kbit++;
                end
            end else begin
                chk("idle_bits", {core_a_bit, core_b_bit}, 0);
                if (dcnt == 0) begin
                    core_done   = 1'b1;
                    core_cipher = 8'(cur.cip);
                end
                if (dcnt >= 0) dcnt--;
            end
            if (core_start) begin
                if (plans.size() == 0) begin
                    chk("start_without_grant", 1, 0);
                end else begin
                    cur        = plans.pop_front();
                    collecting = 1'b1;
                    kbit       = 0;
                    dcnt       = -1;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Response monitor.
    // ------------------------------------------------------------------
    bit        holding = 1'b0;
    logic [9:0] h_vec;
    rsp_t      e;

    always @(negedge clk) begin
        if (rst) begin
            holding = 1'b0;
        end else if (rsp_valid) begin
            if (!holding) begin
                if (sb.size() == 0) begin
                    chk("unexpected_rsp", 1, 0);
                end else begin
                    e = sb.pop_front();
                    chk("rsp_id", rsp_id, e.id);
                    chk("rsp_data", rsp_data, e.data);
                    chk("rsp_err", rsp_err, e.err);
                    chk("rsp_cycle", cyc, e.cyc);
                end
                h_vec   = {rsp_id, rsp_data, rsp_err};
                holding = 1'b1;
            end else begin
                chk("rsp_stable", {rsp_id, rsp_data, rsp_err}, h_vec);
            end
            if (rsp_ready) holding = 1'b0;
        end else begin
            if (holding) begin
                chk("rsp_dropped", 0, 1);
                holding = 1'b0;
            end
            if (sb.size() > 0 && cyc > sb[0].cyc) begin
                chk("rsp_missing", 0, 1);
                void'(sb.pop_front());
            end
        end
    end

    // ------------------------------------------------------------------
    // Stimulus helpers.
    // ------------------------------------------------------------------
    task automatic raise(input int n, input int a, input int b, input int w, input int cip);
        vld[n]  = 1'b1;
        opa[n]  = 8'(a);
        opb[n]  = 8'(b);
        pw[n]   = w;
        pcip[n] = 8'(cip);
    endtask

    function automatic int rand_w();
        case ($urandom_range(0, 9))
            0:       return NEVER;
            1:       return TIMEOUT - 1;
            2:       return TIMEOUT;
            3:       return TIMEOUT + int'($urandom_range(1, 5));
            default: return int'($urandom_range(0, 6));
        endcase
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
        for (int n = 0; n < 2; n++) begin
            if (acc[n]) begin
                vld[n] = 1'b0;
                acc[n] = 1'b0;
            end
            if (!vld[n] && (keep_both || (auto_en && $urandom_range(0, 3) == 0)))
                raise(n, $urandom, $urandom,
                      keep_both ? int'($urandom_range(0, 4)) : rand_w(), $urandom);
        end
        if (auto_en) rsp_ready = ($urandom_range(0, 1) == 1);
    endtask

    task automatic drain(input string nm);
        int k = 0;
        while (!(idle_m && !vld[0] && !vld[1] && sb.size() == 0) && k < 3000) begin
            step();
            k++;
        end
        chk({"drain_", nm}, int'(k < 3000), 1);
    endtask

    task automatic do_reset(input bit with_valid);
        auto_en   = 1'b0;
        keep_both = 1'b0;
        rst       = 1'b1;
        rsp_ready = 1'b0;
        acc[0]    = 1'b0;
        acc[1]    = 1'b0;
        vld[0]    = with_valid;
        vld[1]    = with_valid;
        repeat (3) step();
        vld[0] = 1'b0;
        vld[1] = 1'b0;
        rst    = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        for (int n = 0; n < 2; n++) begin
            vld[n] = 1'b0; opa[n] = 8'h00; opb[n] = 8'h00;
            pw[n] = 0; pcip[n] = 8'h00; acc[n] = 1'b0;
        end

        // Reset with both requesters offering: everything must stay at zero.
        do_reset(1'b1);

        // Directed single transaction: A=0x02, B=0x03, done 3 cycles after last bit.
        rsp_ready = 1'b1;
        spur_mode = 2;
        step();
        raise(0, 8'h02, 8'h03, 2, 8'h5A);
        drain("basic");

        // Round-robin order from reset with both requesters always valid.
        do_reset(1'b0);
        glog.delete();
        rsp_ready = 1'b1;
        keep_both = 1'b1;
        k = 0;
        while (glog.size() < 4 && k < 500) begin step(); k++; end
        keep_both = 1'b0;
        drain("rr");
        chk("rr_count", int'(glog.size() >= 4), 1);
        if (glog.size() >= 4)
            for (int i = 0; i < 4; i++) chk("rr_order", glog[i], i % 2);

        // Core never answers: timeout response.
        step();
        raise(0, $urandom, $urandom, NEVER, $urandom);
        drain("timeout");

        // Completion pulses only during SHIFT are ignored.
        spur_mode = 1;
        step();
        raise(1, $urandom, $urandom, NEVER, $urandom);
        drain("spurious");
        spur_mode = 0;

        // Consumer stalls the response; a new request must not be granted.
        rsp_ready = 1'b0;
        step();
        raise(0, $urandom, $urandom, 1, $urandom);
        k = 0;
        while (cyc < rsp_cyc && k < 100) begin step(); k++; end
        raise(1, $urandom, $urandom, 3, $urandom);
        repeat (10) step();
        rsp_ready = 1'b1;
        drain("stall");

        // Reset during SHIFT bit 4 after a requester-0 grant.
        do_reset(1'b0);
        step();
        raise(0, $urandom, $urandom, 1, $urandom);
        repeat (6) step();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        glog.delete();
        rsp_ready = 1'b1;
        raise(0, $urandom, $urandom, 2, $urandom);
        raise(1, $urandom, $urandom, 2, $urandom);
        k = 0;
        while (glog.size() < 1 && k < 50) begin step(); k++; end
        chk("post_reset_grant_seen", int'(glog.size() >= 1), 1);
        if (glog.size() >= 1) chk("post_reset_grant", glog[0], 0);
        drain("post_reset");

        // Randomised traffic.
        auto_en = 1'b1;
        repeat (800) step();
        auto_en   = 1'b0;
        rsp_ready = 1'b1;
        drain("random");

        chk("sb_empty", sb.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
